// File: rtl/subinst_sched_pkg.sv
// Shared definitions for the sub-instance round-robin scheduler.
//   sched_state_t : FSM state encoding (IDLE / GRANT / GAP)
//   DEF_*         : default parameter values for the scheduler and picker
//   rr_pick       : reference round-robin pick over up to 16 requesters,
//                   returns {found, id[3:0]}
package subinst_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } sched_state_t;

    localparam int DEF_N_REQ    = 5;
    localparam int DEF_ID_W     = 3;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_HOLD_W   = 5;
    localparam int MAX_N_REQ    = 16;

    // Searches last_id+1 .. last_id (mod n); the lowest offset wins, so the
    // loop walks offsets downward and lets the last hit stand.
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last_id,
                                           input int          n);
        logic [4:0] res;
        int         idx;
        res = '0;
        for (int i = MAX_N_REQ; i >= 1; i--) begin
            if (i <= n) begin
                idx = (int'(last_id) + i) % n;
                if (req[idx]) res = {1'b1, 4'(idx)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subinst_rr_pick.sv
// Combinational round-robin picker.
//   req     in  N_REQ  level requests
//   last_id in  ID_W   most recently served requester
//   found   out 1      at least one request is pending
//   id      out ID_W   next requester after last_id with req set
// The request vector is rotated so last_id+1 lands at bit 0, priority
// encoded from the bottom, and the offset is rotated back to an index.
module subinst_rr_pick
    import subinst_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic             found,
    output logic [ID_W-1:0]  id
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    int                 start;
    int                 offset;
    int                 sum;

    always_comb begin
        found   = 1'b0;
        id      = '0;
        offset  = 0;
        req_dbl = {req, req};
        start   = (int'(last_id) >= N_REQ - 1) ? 0 : int'(last_id) + 1;
        req_rot = N_REQ'(req_dbl >> start);
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end
        sum = start + offset;
        if (sum >= N_REQ) sum = sum - N_REQ;
        id = ID_W'(sum);
    end

endmodule

// File: rtl/subinst_rr_scheduler.sv
// Round-robin scheduler sharing one downstream resource between sibling
// instances. One-hot registered grant, bounded hold time, one dead cycle
// between grants for bus turnaround.
//   clk          in  1      clock, all logic on posedge
//   rst_n        in  1      synchronous reset, active-low
//   req          in  N_REQ  level request per requester
//   done         in  N_REQ  release pulse, only the granted bit counts
//   gnt          out N_REQ  one-hot grant, zero when idle
//   gnt_id       out ID_W   granted index, zero when idle
//   gnt_valid    out 1      grant active
//   timeout      out 1      high during the grant cycle that hits MAX_HOLD
//   grant_count  out 16     grants issued, wrapping
//
// state   | meaning
// S_IDLE  | no grant, waiting for any request
// S_GRANT | gnt held, hold_cnt counting 1..MAX_HOLD
// S_GAP   | one dead cycle after release, re-arbitrates from last_id+1
module subinst_rr_scheduler
    import subinst_sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int ID_W     = DEF_ID_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              gnt_valid,
    output logic              timeout,
    output logic [15:0]       grant_count
);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(N_REQ - 1);

    sched_state_t      state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   last_id;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              release_now;

    subinst_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (req),
        .last_id (last_id),
        .found   (pick_found),
        .id      (pick_id)
    );

    always_comb begin
        release_now = done[gnt_id] | ~req[gnt_id] | (hold_cnt == HOLD_MAX);
    end

    // timeout is registered, so it is raised one edge early (when hold_cnt
    // is about to reach MAX_HOLD) to line up with the final grant cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gnt         <= '0;
            gnt_id      <= '0;
            gnt_valid   <= 1'b0;
            timeout     <= 1'b0;
            grant_count <= '0;
            hold_cnt    <= '0;
            last_id     <= LAST_INIT;
        end else begin
            case (state)
                S_IDLE, S_GAP: begin
                    timeout <= 1'b0;
                    if (pick_found) begin
                        state       <= S_GRANT;
                        gnt         <= N_REQ'(1) << pick_id;
                        gnt_id      <= pick_id;
                        gnt_valid   <= 1'b1;
                        hold_cnt    <= HOLD_W'(1);
                        timeout     <= (MAX_HOLD == 1);
                        grant_count <= grant_count + 16'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (release_now) begin
                        state     <= S_GAP;
                        gnt       <= '0;
                        gnt_id    <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b0;
                        hold_cnt  <= '0;
                        last_id   <= gnt_id;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        timeout  <= (hold_cnt == HOLD_PRE);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
module tb_subinst_rr_scheduler;

    localparam int N_REQ    = 5;
    localparam int ID_W     = 3;
    localparam int MAX_HOLD = 16;
    localparam int HOLD_W   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;
    logic             timeout;
    logic [15:0]      grant_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    subinst_rr_scheduler #(
        .N_REQ    (N_REQ),
        .ID_W     (ID_W),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .gnt_valid   (gnt_valid),
        .timeout     (timeout),
        .grant_count (grant_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    int         order [6] = '{0, 1, 2, 3, 4, 0};
    logic [4:0] exp_gnt;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        step();
        step();
        check("rst_gnt",       32'(gnt),         32'h0);
        check("rst_gnt_id",    32'(gnt_id),      32'h0);
        check("rst_valid",     32'(gnt_valid),   32'h0);
        check("rst_timeout",   32'(timeout),     32'h0);
        check("rst_count",     32'(grant_count), 32'h0);

        // idle with no requests
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_gnt",   32'(gnt),       32'h0);
            check("idle_valid", 32'(gnt_valid), 32'h0);
        end
        check("idle_count", 32'(grant_count), 32'h0);

        // full rotation with done pulses
        req = 5'b11111;
        step();
        for (int i = 0; i < 6; i++) begin
            exp_gnt = 5'(1) << order[i];
            check("rot_gnt",    32'(gnt),       32'(exp_gnt));
            check("rot_gnt_id", 32'(gnt_id),    32'(order[i]));
            check("rot_valid",  32'(gnt_valid), 32'h1);
            step();
            step();
            check("rot_hold", 32'(gnt), 32'(exp_gnt));
            done = exp_gnt;
            step();
            done = '0;
            check("rot_gap_gnt",   32'(gnt),       32'h0);
            check("rot_gap_valid", 32'(gnt_valid), 32'h0);
            if (i == 5) req = '0;
            step();
        end
        check("rot_idle_gnt", 32'(gnt),         32'h0);
        check("rot_count",    32'(grant_count), 32'd6);

        // single requester, hold budget expires
        req = 5'b00100;
        step();
        for (int c = 1; c <= 16; c++) begin
            check("to_gnt",     32'(gnt),     32'h04);
            check("to_timeout", 32'(timeout), (c == 16) ? 32'h1 : 32'h0);
            step();
        end
        check("to_gap_gnt",     32'(gnt),     32'h0);
        check("to_gap_timeout", 32'(timeout), 32'h0);
        step();
        check("to_regrant_gnt", 32'(gnt),         32'h04);
        check("to_regrant_id",  32'(gnt_id),      32'd2);
        check("to_count",       32'(grant_count), 32'd8);
        req = '0;
        step();
        check("drop_release", 32'(gnt), 32'h0);
        step();

        // done on a non-granted bit is ignored
        req = 5'b00010;
        step();
        check("nd_gnt", 32'(gnt), 32'h02);
        done = 5'b01000;
        step();
        check("nd_ignored", 32'(gnt), 32'h02);
        done = 5'b00010;
        step();
        done = '0;
        check("nd_release", 32'(gnt), 32'h0);
        check("nd_count",   32'(grant_count), 32'd9);
        req = '0;
        step();

        // reset in the middle of a grant
        req = 5'b01000;
        step();
        check("mr_gnt_id", 32'(gnt_id), 32'd3);
        step();
        step();
        rst_n = 1'b0;
        step();
        check("mr_gnt",     32'(gnt),         32'h0);
        check("mr_gnt_id0", 32'(gnt_id),      32'h0);
        check("mr_valid",   32'(gnt_valid),   32'h0);
        check("mr_timeout", 32'(timeout),     32'h0);
        check("mr_count",   32'(grant_count), 32'h0);
        rst_n = 1'b1;
        req   = 5'b11111;
        step();
        check("mr_first_gnt", 32'(gnt),         32'h01);
        check("mr_first_id",  32'(gnt_id),      32'd0);
        check("mr_count1",    32'(grant_count), 32'd1);
        req = '0;
        step();
        step();

        // grant counter wrap
        force dut.grant_count = 16'hFFFF;
        step();
        release dut.grant_count;
        check("wrap_pre", 32'(grant_count), 32'hFFFF);
        req = 5'b00001;
        step();
        check("wrap_gnt",   32'(gnt),         32'h01);
        check("wrap_count", 32'(grant_count), 32'h0);
        req = '0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
